// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked arbiter that shares one FIFO
// write port among NUM_REQ valid/ready producers.
//
// Optional build macro: ARB_STATS_EN adds per-requester accepted-beat
// counters (beat_count) and an owner-stall cycle counter (stall_cycles).
//
// Handshake: requester i transfers a word on a rising edge when
// req_valid[i] and req_ready[i] are both high at that edge. req_ready is at
// most one-hot (only the current owner) and is the inverse of fifo_full
// while that requester owns the port. The word is written into the FIFO on
// that same edge (fifo_wr_en high), so acceptance and FIFO write coincide.
// While reset is high every output is forced to its idle value so no
// transfer or write can happen on a reset edge.
//
// The FSM state is visible on gnt_valid (OWN) and gnt_id (owner index).

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_wr_en,
  output logic [DATA_WIDTH-1:0]        fifo_wr_data,
  input  logic                         fifo_full,
  output logic                         gnt_valid,
  output logic [ID_WIDTH-1:0]          gnt_id
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        beat_count,
  output logic [15:0]                  stall_cycles
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  // Burst counter is sized for the largest legal MAX_BURST (255).
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [CNT_W-1:0]    beat_cnt;

  logic                owner_valid;
  logic                xfer;
  logic                release_grant;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                idle_found;
  logic [ID_WIDTH-1:0] idle_sel;
  logic                rel_found;
  logic [ID_WIDTH-1:0] rel_sel;

  // First valid requester at or after 'start', wrapping explicitly modulo
  // NUM_REQ so a non-power-of-2 NUM_REQ never yields an out-of-range index.
  // Returns {found, index}.
  function automatic logic [ID_WIDTH:0] rr_pick(
    input logic [ID_WIDTH-1:0] start,
    input logic [NUM_REQ-1:0]  v
  );
    logic                found;
    logic [ID_WIDTH-1:0] sel;
    int                  idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && v[idx]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
    return {found, sel};
  endfunction

  // Transfer / release decode for the current owner.
  always_comb begin
    owner_valid   = req_valid[owner];
    xfer          = (state == S_OWN) && owner_valid && !fifo_full && !reset;
    // Release after the last beat of a burst, or as soon as the owner
    // drops valid (even while the FIFO is full).
    release_grant = (state == S_OWN) &&
                    ((xfer && (beat_cnt == LAST_BEAT)) || !owner_valid);
    if (int'(owner) == NUM_REQ - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = owner + 1'b1;
    end
  end

  // Two searches: from rr_ptr when idle, from owner+1 on release so the
  // previous owner is considered last.
  always_comb begin
    {idle_found, idle_sel} = rr_pick(rr_ptr, req_valid);
    {rel_found, rel_sel}   = rr_pick(next_ptr, req_valid);
  end

  // Port-facing outputs follow the state and the live inputs.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    gnt_valid    = 1'b0;
    gnt_id       = '0;
    if ((state == S_OWN) && !reset) begin
      gnt_valid        = 1'b1;
      gnt_id           = owner;
      req_ready[owner] = !fifo_full;
      fifo_wr_en       = xfer;
      fifo_wr_data     = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Arbiter FSM: IDLE picks an owner (1-cycle arbitration); OWN counts
  // beats and hands over without a bubble when another requester waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_found) begin
            state    <= S_OWN;
            owner    <= idle_sel;
            beat_cnt <= '0;
          end
        end
        S_OWN: begin
          if (release_grant) begin
            rr_ptr <= next_ptr;
            if (rel_found) begin
              owner    <= rel_sel;
              beat_cnt <= '0;
            end else begin
              state    <= S_IDLE;
              owner    <= '0;
              beat_cnt <= '0;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          owner    <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating statistics: accepted beats per requester and owner stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count   <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && (int'(owner) == i) &&
            (beat_count[i*16 +: 16] != 16'hFFFF)) begin
          beat_count[i*16 +: 16] <= beat_count[i*16 +: 16] + 16'd1;
        end
      end
      if ((state == S_OWN) && owner_valid && fifo_full &&
          (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers driven with $urandom, a
// transaction-level reference model predicts per-cycle port status and the
// sequence of words entering the FIFO; a monitor compares at the falling edge.

module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic              gnt_valid;
  logic [IW-1:0]     gnt_id;
`ifdef ARB_STATS_EN
  logic [NR*16-1:0]  beat_count;
  logic [15:0]       stall_cycles;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .ID_WIDTH(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id)
`ifdef ARB_STATS_EN
    ,
    .beat_count(beat_count),
    .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          gv;
    logic [IW-1:0] id;
    logic          we;
    logic [NR-1:0] rdy;
    logic [DW-1:0] wd;
  } stat_t;

  stat_t         st_q[$];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  // ---------------- producers ----------------
  logic [NR-1:0] pv;
  logic [DW-1:0] pd   [NR];
  logic [DW-1:0] dctr [NR];

  // ---------------- reference model ----------------
  // Who holds the port, where the next idle search starts, beats so far.
  bit m_own;
  int m_owner;
  int m_rr;
  int m_beats;

  function automatic int pick(input int start, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(start + k) % NR]) return (start + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_step();
    stat_t s;
    int    p;
    bit    x;
    bit    done;
    s = '0;
    if (reset) begin
      m_own = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    end else if (!m_own) begin
      p = pick(m_rr, req_valid);
      if (p >= 0) begin
        m_own = 1; m_owner = p; m_beats = 0;
      end
    end else begin
      s.gv = 1'b1;
      s.id = IW'(m_owner);
      s.wd = pd[m_owner];
      x = req_valid[m_owner] && !fifo_full;
      if (!fifo_full) s.rdy[m_owner] = 1'b1;
      s.we = x;
      if (x) begin
        exp_q.push_back(pd[m_owner]);
        pv[m_owner] = 1'b0;
        m_beats++;
      end
      done = x ? (m_beats == MB) : !req_valid[m_owner];
      if (done) begin
        m_rr = (m_owner + 1) % NR;
        p = pick(m_rr, req_valid);
        if (p >= 0) begin
          m_owner = p; m_beats = 0;
        end else begin
          m_own = 0; m_owner = 0; m_beats = 0;
        end
      end
    end
    st_q.push_back(s);
  endtask

  // ---------------- driver ----------------
  // rate: % chance an idle producer raises a new word; drop: % chance a
  // waiting producer withdraws; full_pct / rst_pct: % of cycles with
  // fifo_full / reset high.
  task automatic drive_cycle(input int rate, input logic [NR-1:0] mask,
                             input int drop, input int full_pct,
                             input int rst_pct);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (!pv[i] && mask[i] && ($urandom_range(0, 99) < rate)) begin
        pv[i] = 1'b1;
        pd[i] = dctr[i];
        dctr[i] = dctr[i] + 8'd1;
      end else if (pv[i] && ($urandom_range(0, 99) < drop)) begin
        pv[i] = 1'b0;
      end
    end
    reset     = ($urandom_range(0, 99) < rst_pct);
    fifo_full = ($urandom_range(0, 99) < full_pct);
    req_valid = pv;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pd[i];
    model_step();
  endtask

  task automatic run(input int n, input int rate, input logic [NR-1:0] mask,
                     input int drop, input int full_pct, input int rst_pct);
    for (int c = 0; c < n; c++) drive_cycle(rate, mask, drop, full_pct, rst_pct);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    stat_t         e;
    stat_t         a;
    logic [DW-1:0] d;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      a = {gnt_valid, gnt_id, fifo_wr_en, req_ready, fifo_wr_data};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL status t=%0t actual gv=%b id=%0d we=%b rdy=%b wd=%h required gv=%b id=%0d we=%b rdy=%b wd=%h",
                 $time, a.gv, a.id, a.we, a.rdy, a.wd, e.gv, e.id, e.we, e.rdy, e.wd);
      end
      if (fifo_wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fifo_write t=%0t actual=%h required=<no write>", $time, fifo_wr_data);
        end else begin
          d = exp_q.pop_front();
          if (fifo_wr_data !== d) begin
            errors++;
            $display("FAIL fifo_write t=%0t actual=%h required=%h", $time, fifo_wr_data, d);
          end
        end
      end
    end
  end

  // ---------------- stimulus sequence and report ----------------
  initial begin
    reset     = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    pv        = '0;
    m_own = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    for (int i = 0; i < NR; i++) begin
      pd[i]   = '0;
      dctr[i] = DW'(i * 64);
    end
    repeat (2) @(posedge clk);

    // Reset held, then five quiet cycles.
    run(2, 0, 4'b0000, 0, 0, 100);
    run(5, 0, 4'b0000, 0, 0, 0);

    // Requester 2 alone, streaming 0x10.. with no backpressure.
    dctr[2] = 8'h10;
    run(12, 100, 4'b0100, 0, 0, 0);

    // All requesters streaming from a fresh reset.
    pv = '0;
    run(1, 0, 4'b0000, 0, 0, 100);
    run(40, 100, 4'b1111, 0, 0, 0);

    // Streaming under random FIFO backpressure.
    run(80, 100, 4'b1111, 0, 35, 0);

    // Sparse requests with withdrawals.
    run(120, 30, 4'b1111, 15, 10, 0);

    // Everything random, including occasional mid-burst resets.
    run(500, 50, 4'b1111, 8, 20, 3);

    // Drain: let any outstanding status reach the monitor.
    run(1, 0, 4'b0000, 0, 0, 100);
    repeat (2) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (st_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_status actual=%0d required=0", st_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
